// File: rtl/if_id_stall_ctrl.sv
// rtl/if_id_stall_ctrl.sv - IF/ID pipeline register with load-use stall and branch flush control
module if_id_stall_ctrl #(
  parameter logic [31:0] NOP_INSTR = 32'hD503201F,
  parameter int          MAX_STALL = 2,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic [63:0]      if_pc,
  input  logic [31:0]      if_instr,
  input  logic             if_valid,
  input  logic             reg2loc,
  output logic             pc_write_en,
  output logic [63:0]      id_pc,
  output logic [31:0]      id_instr,
  output logic             id_valid,
  output logic [4:0]       id_rs1,
  output logic [4:0]       id_rs2,
  output logic             id_ex_bubble,
  output logic             id_ex_flush,
  output logic             stall_err,
  output logic [CNT_W-1:0] stall_count
);

  // hold_cnt only needs to reach MAX_STALL, where it saturates
  localparam int                HOLD_W   = $clog2(MAX_STALL + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_STALL);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_cnt_next;
  logic              stall_err_next;
  logic [HOLD_W:0]   hold_inc;
  logic              eff_stall;

  // A bubble never stalls, and a taken branch overrides any stall request
  assign eff_stall = stall & id_valid & ~flush;

  // Control outputs react in the same cycle as stall/flush
  assign pc_write_en  = ~eff_stall;
  assign id_ex_bubble = eff_stall;
  assign id_ex_flush  = flush;

  // Source register fields for the hazard unit; reg2loc picks the store/CBZ form
  assign id_rs1 = id_instr[9:5];
  assign id_rs2 = reg2loc ? id_instr[4:0] : id_instr[20:16];

  assign hold_inc = {1'b0, hold_cnt} + {{HOLD_W{1'b0}}, 1'b1};

  // IF/ID latch: flush loads a NOP bubble, stall holds, otherwise capture IF
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_pc    <= 64'd0;
      id_instr <= NOP_INSTR;
      id_valid <= 1'b0;
    end else if (flush) begin
      id_pc    <= if_pc;
      id_instr <= NOP_INSTR;
      id_valid <= 1'b0;
    end else if (!eff_stall) begin
      id_pc    <= if_pc;
      id_instr <= if_instr;
      id_valid <= if_valid;
    end
  end

  // Stall-tracking FSM state, duration counter and sticky error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      hold_cnt  <= '0;
      stall_err <= 1'b0;
    end else begin
      state     <= state_next;
      hold_cnt  <= hold_cnt_next;
      stall_err <= stall_err_next;
    end
  end

  // Next-state logic: RUN enters HOLD on a stall, HOLD leaves as soon as the stall ends
  always_comb begin
    state_next     = state;
    hold_cnt_next  = hold_cnt;
    stall_err_next = stall_err;
    case (state)
      RUN: begin
        if (eff_stall) begin
          state_next    = HOLD;
          hold_cnt_next = HOLD_ONE;
        end
      end
      HOLD: begin
        if (eff_stall) begin
          state_next = HOLD;
          if (hold_inc >= {1'b0, HOLD_MAX}) begin
            hold_cnt_next  = HOLD_MAX;
            stall_err_next = 1'b1;
          end else begin
            hold_cnt_next = hold_inc[HOLD_W-1:0];
          end
        end else begin
          state_next    = RUN;
          hold_cnt_next = '0;
        end
      end
      default: begin
        state_next    = RUN;
        hold_cnt_next = '0;
      end
    endcase
  end

  // Saturating count of every stalled cycle; never wraps back to zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (eff_stall && (stall_count != CNT_MAX)) begin
      stall_count <= stall_count + CNT_ONE;
    end
  end

endmodule

// File: doc/if_id_stall_ctrl.md
Name: if_id_stall_ctrl

Overview:
- IF/ID pipeline register plus the stall/flush controller that acts on the load-use `stall` from the hazard detection unit.
- Holds the fetched PC and instruction. Drives the decoded source-register fields back to the hazard unit.
- Applies hazard stall and branch flush to the PC, the IF/ID latch and ID/EX.
- Tracks stall duration and counts stall cycles for performance/debug.

Parameters:
- NOP_INSTR, 32'hD503201F, ARM64 NOP loaded into the IF/ID latch on reset/flush.
- MAX_STALL, 2, consecutive stalled cycles at which `stall_err` sets (a legal load-use stall lasts 1 cycle).
- CNT_W, 32, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- stall  input  1  load-use hazard request from the hazard detection unit (combinational on id_rs1/id_rs2)
- flush  input  1  taken branch resolved downstream; squash younger instructions
- if_pc  input  64  PC of the instruction in IF
- if_instr  input  32  fetched instruction
- if_valid  input  1  IF holds a real instruction
- reg2loc  input  1  from ID control: 1 means rs2 = instr[4:0] (STUR/CBZ), 0 means instr[20:16]
- pc_write_en  output  1  PC register enable
- id_pc  output  64  latched PC
- id_instr  output  32  latched instruction
- id_valid  output  1  IF/ID contents valid
- id_rs1  output  5  id_instr[9:5]
- id_rs2  output  5  reg2loc ? id_instr[4:0] : id_instr[20:16]
- id_ex_bubble  output  1  ID/EX latches zeroed control (bubble) this edge
- id_ex_flush  output  1  ID/EX squash, equals flush
- stall_err  output  1  sticky: stall persisted MAX_STALL cycles
- stall_count  output  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset (async, immediate) values:
  - id_pc = 0, id_instr = NOP_INSTR, id_valid = 0.
  - State = RUN, hold_cnt = 0, stall_err = 0, stall_count = 0.
- Effective stall: eff_stall = stall & id_valid & ~flush. Flush has priority over stall.
- Combinational outputs:
  - pc_write_en = ~eff_stall
  - id_ex_bubble = eff_stall
  - id_ex_flush = flush
  - id_rs1 and id_rs2 are combinational from id_instr and reg2loc.
- IF/ID latch update, per rising edge:
  - flush = 1: id_instr <= NOP_INSTR, id_valid <= 0, id_pc <= if_pc.
  - else eff_stall = 1: all IF/ID fields hold.
  - else: id_pc <= if_pc, id_instr <= if_instr, id_valid <= if_valid.
- FSM states: RUN and HOLD.
  - RUN, eff_stall = 1: go to HOLD, hold_cnt <= 1.
  - RUN, otherwise: stay in RUN.
  - HOLD, eff_stall = 1: stay in HOLD, hold_cnt <= hold_cnt + 1, saturating at MAX_STALL.
  - HOLD, eff_stall = 0: go to RUN, hold_cnt <= 0. This covers flush during HOLD, which leaves on the same edge.
  - stall_err <= 1 when in HOLD with eff_stall = 1 and hold_cnt + 1 >= MAX_STALL. Cleared only by reset.
- stall_count increments by 1 on every edge with eff_stall = 1. It saturates at all-ones and never wraps.
- Simultaneous events:
  - stall & flush: flush wins. No bubble, PC advances, latch loads NOP.
  - stall with id_valid = 0: ignored. Nothing stalls on a bubble.
- Latency:
  - Control outputs are same-cycle with respect to stall/flush.
  - Latch contents appear 1 cycle after capture.
- Reset mid-stall: all state returns to reset values immediately. pc_write_en = 1 while id_valid = 0.

Test Plan:
1. Reset with if_instr = 32'h8B020020, if_valid = 1 -> during reset id_instr = 32'hD503201F, id_valid = 0, pc_write_en = 1; first edge after release latches 32'h8B020020, id_rs1 = 1, id_rs2 = 2 (reg2loc = 0).
2. id_instr = 32'hF84003E1, reg2loc = 1 -> id_rs2 = 1; reg2loc = 0 -> id_rs2 = 0; id_rs1 = 31 in both cases.
3. Load-use: stall = 1 for one cycle with id_valid = 1 -> pc_write_en = 0 and id_ex_bubble = 1 that cycle; id_pc/id_instr unchanged after the edge; stall_count = 1; FSM RUN->HOLD->RUN; stall_err = 0.
4. stall = 1 and flush = 1 together -> pc_write_en = 1, id_ex_bubble = 0, id_ex_flush = 1; next cycle id_instr = NOP, id_valid = 0; stall_count unchanged.
5. stall held 3 cycles (MAX_STALL = 2) -> stall_err rises after the 2nd stalled edge and stays 1 after stall drops; stall_count = 3; async reset mid-stall clears all outputs without a clock edge.
6. CNT_W = 4 build, 20 stalled cycles -> stall_count saturates at 4'hF and does not wrap.
